serial_frame_rx: RTL

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: asynchronous serial frame receiver.
// A frame is one start bit (0), DATA_BITS data bits sent LSB first, then one stop bit (1).
// Each bit is sampled at its centre, timed from the detected falling edge of the start bit.
// Ports:
//   clk, n_rst    - clock (rising edge) and asynchronous active-low reset
//   serial_in     - raw serial line, idle high
//   data_read     - one-cycle consumer acknowledge; clears data_ready
//   rx_data       - last correctly framed data word
//   data_ready    - high while rx_data holds an unread word
//   framing_error - stop bit of the last frame was sampled low
//   overrun_error - an unread word was overwritten by a new frame
module serial_frame_rx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] LOAD  = 3'd4;

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic                 sync1;
  logic                 sync2;
  logic                 sync2_d;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 half_tick_c;
  logic                 full_tick_c;
  logic                 last_bit_c;
  logic                 fall_c;

  // Line synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sync2_d <= 1'b1;
    end else begin
      sync1   <= serial_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // Start bit is checked half a bit after entering START; later bits one full bit apart.
  assign half_tick_c = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign full_tick_c = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit_c  = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign fall_c      = sync2_d & ~sync2;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fall_c) next_state = START;
      START:   if (half_tick_c) next_state = sync2 ? IDLE : DATA;
      DATA:    if (full_tick_c && last_bit_c) next_state = STOP;
      STOP:    if (full_tick_c) next_state = sync2 ? LOAD : IDLE;
      LOAD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bit timing counter, data bit counter and shift register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        START: cnt <= half_tick_c ? '0 : cnt + CNT_W'(1);
        DATA: begin
          cnt <= full_tick_c ? '0 : cnt + CNT_W'(1);
          if (full_tick_c) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            // First data bit enters at the MSB and ends up at bit 0.
            shift   <= {sync2, shift[DATA_BITS-1:1]};
          end
        end
        STOP: cnt <= full_tick_c ? '0 : cnt + CNT_W'(1);
        default: begin
          cnt     <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Output registers; a LOAD takes priority over a concurrent data_read.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (state == IDLE && fall_c) framing_error <= 1'b0;
      if (state == STOP && full_tick_c && !sync2) framing_error <= 1'b1;
      if (state == LOAD) begin
        rx_data       <= shift;
        data_ready    <= 1'b1;
        framing_error <= 1'b0;
        if (data_ready && !data_read) overrun_error <= 1'b1;
      end else if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

endmodule
